// File: rtl/nand_cpu_pkg.sv
// rtl/nand_cpu_pkg.sv - shared CPU widths and instruction-memory loader types
package nand_cpu_pkg;

  localparam int INSTR_WIDTH   = 8;
  localparam int ADDR_WIDTH    = 8;
  localparam int LOADER_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - shifts bytes into a little-endian word and flags completion
module byte_assembler
  import nand_cpu_pkg::*;
#(
  parameter int NBYTES = 2,
  parameter int BYTE_W = LOADER_BYTE_W
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     byte_en,
  input  logic [BYTE_W-1:0]        byte_in,
  output logic [NBYTES*BYTE_W-1:0] word,
  output logic                     complete
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [CW-1:0] cnt;

  // word includes the byte being accepted, so complete and word are valid together
  assign complete = byte_en && (cnt == CW'(NBYTES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (byte_en) begin
      cnt <= complete ? '0 : cnt + CW'(1);
    end
  end

  generate
    if (NBYTES == 1) begin : g_single
      assign word = byte_in;
    end else begin : g_multi
      logic [NBYTES*BYTE_W-1:0] shreg;

      assign word = {byte_in, shreg[NBYTES*BYTE_W-1:BYTE_W]};

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          shreg <= '0;
        end else if (clear) begin
          shreg <= '0;
        end else if (byte_en) begin
          shreg <= word;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a checksummed byte frame into instruction memory
module imem_loader
  import nand_cpu_pkg::*;
#(
  parameter int INSTR_WIDTH = nand_cpu_pkg::INSTR_WIDTH,
  parameter int ADDR_WIDTH  = nand_cpu_pkg::ADDR_WIDTH,
  parameter int LEN_BYTES   = 2
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [LOADER_BYTE_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [INSTR_WIDTH-1:0]   wr_data,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error
);

  localparam int          INSTR_BYTES = INSTR_WIDTH / LOADER_BYTE_W;
  localparam int          LEN_W       = LEN_BYTES * LOADER_BYTE_W;
  localparam int          CNT_W       = ADDR_WIDTH + 1;
  localparam logic [63:0] DEPTH       = 64'd1 << ADDR_WIDTH;

  loader_state_t state, state_next;

  logic                     accept, enter_len, hdr_en, data_en;
  logic                     hdr_done, data_done, hdr_over, last_instr;
  logic [LEN_W-1:0]         hdr_word;
  logic [INSTR_WIDTH-1:0]   data_word;
  logic [LOADER_BYTE_W-1:0] csum;
  logic [CNT_W-1:0]         n_count, instr_cnt;

  assign accept     = in_valid && in_ready;
  assign enter_len  = start && (state == IDLE || state == DONE || state == ERROR);
  assign hdr_en     = accept && (state == LEN);
  assign data_en    = accept && (state == DATA);
  assign hdr_over   = 64'(hdr_word) > DEPTH;
  assign last_instr = (instr_cnt + CNT_W'(1)) == n_count;

  byte_assembler #(.NBYTES(LEN_BYTES), .BYTE_W(LOADER_BYTE_W)) u_hdr (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (enter_len),
    .byte_en  (hdr_en),
    .byte_in  (in_data),
    .word     (hdr_word),
    .complete (hdr_done)
  );

  byte_assembler #(.NBYTES(INSTR_BYTES), .BYTE_W(LOADER_BYTE_W)) u_data (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (enter_len),
    .byte_en  (data_en),
    .byte_in  (in_data),
    .word     (data_word),
    .complete (data_done)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: if (start) state_next = LEN;
      LEN: begin
        in_ready = 1'b1;
        if (hdr_done) begin
          if (hdr_over)            state_next = ERROR;
          else if (hdr_word == '0) state_next = CHK;
          else                     state_next = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (data_done && last_instr) state_next = CHK;
      end
      CHK: begin
        in_ready = 1'b1;
        if (accept) state_next = (in_data == csum) ? DONE : ERROR;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_next = LEN;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_next = LEN;
      end
      default: state_next = IDLE;
    endcase
  end

  // wr_addr is the live instruction index: it advances at the end of each write strobe
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      csum      <= '0;
      n_count   <= '0;
      instr_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      if (enter_len) begin
        csum      <= '0;
        n_count   <= '0;
        instr_cnt <= '0;
        wr_addr   <= '0;
      end else begin
        if (hdr_en || data_en) csum <= csum ^ in_data;
        if (hdr_done) n_count <= CNT_W'(hdr_word);
        if (data_done) begin
          wr_en     <= 1'b1;
          wr_data   <= data_word;
          instr_cnt <= instr_cnt + CNT_W'(1);
        end
        if (wr_en) wr_addr <= wr_addr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for the instruction-memory loader
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       n_rst, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, wr_en, cpu_hold, done, error;
  logic [7:0] wr_addr, wr_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        obs_q[$];
  logic [7:0] payload[$];
  logic [7:0] frame[$];

  imem_loader dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (wr_en) obs_q.push_back('{wr_addr, wr_data, cyc});

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic build_frame(input bit corrupt);
    logic [7:0] x;
    int n;
    n = payload.size();
    frame.delete();
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    foreach (payload[i]) frame.push_back(payload[i]);
    x = 8'h00;
    foreach (frame[i]) x = x ^ frame[i];
    frame.push_back(corrupt ? 8'h00 : x);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered and left just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input bit is_instr, input int idx, input int max_gap);
    int gap;
    int w;
    gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_byte: got in_ready=0 want 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (is_instr) exp_q.push_back('{idx[7:0], b, cyc});
    @(negedge clk);
  endtask

  task automatic send_frame(input int max_gap, input int start_after);
    int n;
    n = {frame[1], frame[0]};
    foreach (frame[i]) begin
      send_byte(frame[i], (i >= 2) && (i < 2 + n), i - 2, max_gap);
      if (i == start_after) do_start();
    end
  endtask

  task automatic check_writes(input string name);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data ||
            obs_q[i].cyc != exp_q[i].cyc) begin
          bad++;
          $display("FAIL %s write %0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                   name, i, obs_q[i].addr, obs_q[i].data, obs_q[i].cyc,
                   exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string name, input logic [3:0] want);
    total++;
    if ({in_ready, cpu_hold, done, error} !== want) begin
      bad++;
      $display("FAIL %s status {ready,hold,done,error}: got %b want %b", name,
               {in_ready, cpu_hold, done, error}, want);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error} !== {2'b00, 16'h0000, 3'b100}) begin
      bad++;
      $display("FAIL reset_values: got %b want %b",
               {in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error}, {2'b00, 16'h0000, 3'b100});
    end
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_status("idle", 4'b0100);
    end
    check_writes("idle_writes");
  endtask

  task automatic test_good_load();
    payload = '{8'hA1, 8'hB2, 8'hC3};
    build_frame(1'b0);
    do_start();
    send_frame(0, -1);
    check_status("good_load", 4'b0010);
    check_writes("good_load");
  endtask

  task automatic test_bad_checksum();
    payload = '{8'hA1, 8'hB2, 8'hC3};
    build_frame(1'b1);
    do_start();
    send_frame(0, -1);
    check_status("bad_csum", 4'b0101);
    check_writes("bad_csum");
    payload.delete();
    for (int i = 0; i < 4; i++) payload.push_back(8'($urandom));
    build_frame(1'b0);
    do_start();
    send_frame(0, -1);
    check_status("recover", 4'b0010);
    check_writes("recover");
  endtask

  task automatic test_oversize();
    frame = '{8'h01, 8'h01};
    do_start();
    send_frame(0, -1);
    check_status("oversize", 4'b0101);
    repeat (3) @(negedge clk);
    check_status("oversize_hold", 4'b0101);
    check_writes("oversize");
  endtask

  task automatic test_back_to_back_stall();
    payload.delete();
    for (int i = 0; i < 8; i++) payload.push_back(8'($urandom));
    build_frame(1'b0);
    do_start();
    send_frame(3, 4);
    check_status("stall", 4'b0010);
    check_writes("stall");
    payload = '{8'hA1, 8'hB2, 8'hC3};
    build_frame(1'b0);
    do_start();
    send_frame(2, -1);
    check_status("stall_abc", 4'b0010);
    check_writes("stall_abc");
  endtask

  task automatic test_async_reset();
    do_start();
    send_byte(8'h03, 1'b0, 0, 0);
    send_byte(8'h00, 1'b0, 0, 0);
    send_byte(8'hA1, 1'b1, 0, 0);
    in_valid = 1'b1;
    in_data  = 8'hB2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_rst    = 1'b0;
    #1;
    total++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error} !== {2'b00, 16'h0000, 3'b100}) begin
      bad++;
      $display("FAIL async_reset: got %b want %b",
               {in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error}, {2'b00, 16'h0000, 3'b100});
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_writes("async_reset");
    payload = '{8'h11, 8'h22, 8'h33};
    build_frame(1'b0);
    do_start();
    send_frame(0, -1);
    check_status("after_reset", 4'b0010);
    check_writes("after_reset");
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_oversize();
    test_back_to_back_stall();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
